// File: rtl/cpu_mc.sv
// cpu_mc: multi-cycle core running the 16-bit instruction set over handshaked imem/dmem ports.
// Optional macro CPU_MC_TRAP_EN: opcodes 9-E halt with trap instead of executing as NOP.
module cpu_mc #(
    parameter int XLEN   = 16,
    parameter int ADDR_W = 16,
    parameter int PC_RST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [15:0]       i_imem_rdata,
    input  logic              i_imem_ready,
    output logic              o_dmem_req,
    output logic              o_dmem_we,
    output logic [ADDR_W-1:0] o_dmem_addr,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic [XLEN-1:0]   i_dmem_rdata,
    input  logic              i_dmem_ready,
    output logic              o_retire,
    output logic              o_halted,
    output logic              o_trap
);
    typedef enum logic [2:0] {
        S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic [XLEN-1:0]   r_a, r_b, r_alu, r_mdr;
    logic [XLEN-1:0]   r_regs [16];

    logic [3:0]        w_op, w_rs, w_rt, w_rd;
    logic [XLEN-1:0]   w_sx, w_alu, w_rf_data;
    logic [ADDR_W-1:0] w_pc_inc, w_pc_br, w_pc_jmp, w_pc_nxt;
    logic [3:0]        w_rf_addr;
    logic              w_imem_req, w_dmem_req, w_retire, w_pc_we, w_rf_we;
`ifdef CPU_MC_TRAP_EN
    logic              w_illegal, w_trap_set, r_trap;
`endif

    assign w_op = r_ir[15:12];
    assign w_rs = r_ir[11:8];
    assign w_rt = r_ir[7:4];
    assign w_rd = r_ir[3:0];
    assign w_sx = {{(XLEN-4){r_ir[3]}}, r_ir[3:0]};

    // PC math wraps naturally at ADDR_W bits.
    assign w_pc_inc = r_pc + ADDR_W'(2);
    assign w_pc_br  = w_pc_inc + {{(ADDR_W-5){r_ir[3]}}, r_ir[3:0], 1'b0};
    assign w_pc_jmp = ADDR_W'({r_ir[11:0], 1'b0});

    assign w_rf_addr = (w_op < OP_ADDI) ? w_rd : w_rt;
    assign w_rf_data = (w_op == OP_LW) ? r_mdr : r_alu;

`ifdef CPU_MC_TRAP_EN
    assign w_illegal = (w_op >= 4'h9) && (w_op <= 4'hE);
`endif

    always_comb begin
        w_alu = r_a + w_sx;
        case (w_op)
            OP_ADD:  w_alu = r_a + r_b;
            OP_SUB:  w_alu = r_a - r_b;
            OP_AND:  w_alu = r_a & r_b;
            OP_OR:   w_alu = r_a | r_b;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_retire    = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_nxt    = w_pc_inc;
        w_rf_we     = 1'b0;
`ifdef CPU_MC_TRAP_EN
        w_trap_set  = 1'b0;
`endif
        case (r_state)
            S_BOOT: w_state_nxt = S_FETCH;
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (i_imem_ready) w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_op == OP_HALT) w_state_nxt = S_HALT;
`ifdef CPU_MC_TRAP_EN
                else if (w_illegal) begin
                    w_state_nxt = S_HALT;
                    w_trap_set  = 1'b1;
                end
`endif
                else w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                case (w_op)
                    OP_LW, OP_SW: w_state_nxt = S_MEM;
                    OP_BEQ: begin
                        w_pc_we     = 1'b1;
                        w_pc_nxt    = (r_a == r_b) ? w_pc_br : w_pc_inc;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                    OP_JMP: begin
                        w_pc_we     = 1'b1;
                        w_pc_nxt    = w_pc_jmp;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                    // ALU ops, ADDI and (without trapping) opcodes 9-E all go to WB
                    default: w_state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                if (i_dmem_ready) begin
                    if (w_op == OP_LW) begin
                        w_state_nxt = S_WB;
                    end else begin
                        w_pc_we     = 1'b1;
                        w_retire    = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_WB: begin
                w_rf_we     = (w_op <= OP_LW);
                w_pc_we     = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: ;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_BOOT;
            r_pc    <= ADDR_W'(PC_RST);
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
            for (int k = 0; k < 16; k++) r_regs[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pc_we) r_pc <= w_pc_nxt;
            if (r_state == S_FETCH && i_imem_ready) r_ir <= i_imem_rdata;
            if (r_state == S_DECODE) begin
                r_a <= r_regs[w_rs];
                r_b <= r_regs[w_rt];
            end
            if (r_state == S_EXEC) r_alu <= w_alu;
            if (r_state == S_MEM && i_dmem_ready) r_mdr <= i_dmem_rdata;
            // R0 is never written, so it always reads zero.
            if (w_rf_we && w_rf_addr != 4'd0) r_regs[w_rf_addr] <= w_rf_data;
        end
    end

`ifdef CPU_MC_TRAP_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)           r_trap <= 1'b0;
        else if (w_trap_set) r_trap <= 1'b1;
    end
    assign o_trap = r_trap & ~i_rst;
`else
    assign o_trap = 1'b0;
`endif

    generate
        if (ADDR_W <= XLEN) begin : g_addr_trunc
            assign o_dmem_addr = r_alu[ADDR_W-1:0];
        end else begin : g_addr_zext
            assign o_dmem_addr = {{(ADDR_W-XLEN){1'b0}}, r_alu};
        end
    endgenerate

    // Everything visible is forced quiet while reset is held.
    assign o_imem_req   = w_imem_req & ~i_rst;
    assign o_imem_addr  = r_pc;
    assign o_dmem_req   = w_dmem_req & ~i_rst;
    assign o_dmem_we    = w_dmem_req & (w_op == OP_SW) & ~i_rst;
    assign o_dmem_wdata = r_b;
    assign o_retire     = w_retire & ~i_rst;
    assign o_halted     = (r_state == S_HALT) & ~i_rst;

endmodule

// File: tb/tb_cpu_mc.sv
// tb_cpu_mc: table-driven, directed and randomized checks of cpu_mc against an ISA-level model.
module tb_cpu_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ready = 1'b0;
    logic [15:0] imem_addr, imem_rdata = 16'h0;
    logic        dmem_req, dmem_we, dmem_ready = 1'b0;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata = 16'h0;
    logic        retire, halted, trap;

    cpu_mc #(.XLEN(16), .ADDR_W(16), .PC_RST(0)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_rdata(imem_rdata), .i_imem_ready(imem_ready),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata), .i_dmem_ready(dmem_ready),
        .o_retire(retire), .o_halted(halted), .o_trap(trap)
    );

    always #5 clk = ~clk;

    logic [15:0] imem [0:32767];
    logic [15:0] dmem [0:65535];
    logic [15:0] prog [$];
    logic [15:0] fetch_q [$];
    logic [15:0] st_a_q [$];
    logic [15:0] st_d_q [$];
    int          ret_q [$];
    logic [15:0] exp_a [$];
    logic [15:0] exp_d [$];

    int cyc = 0, icnt = 0, dcnt = 0, itgt = 0, dtgt = 0;
    int iwait = 0, dwait = 0;
    bit irnd = 0, drnd = 0, ispur = 0, dspur = 0, ibusy = 0, dbusy = 0;
    int n_chk = 0, n_pass = 0;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] exp;
    } alu_vec_t;
    alu_vec_t tbl [8];

    function automatic logic [15:0] init_d(input int a);
        logic [31:0] t;
        t = a * 32'h9E37;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [31:0] fq(input int i);
        return (i < fetch_q.size()) ? {16'h0, fetch_q[i]} : 32'hDEADBEEF;
    endfunction
    function automatic logic [31:0] rq(input int i);
        return (i < ret_q.size()) ? ret_q[i] : 32'hDEADBEEF;
    endfunction
    function automatic logic [31:0] sa(input int i);
        return (i < st_a_q.size()) ? {16'h0, st_a_q[i]} : 32'hDEADBEEF;
    endfunction
    function automatic logic [31:0] sd(input int i);
        return (i < st_d_q.size()) ? {16'h0, st_d_q[i]} : 32'hDEADBEEF;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Memory responders and event logging; ready is decided at negedge so the
    // handshake completes on the following posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) cyc = 0; else cyc++;
            if (imem_req) begin
                if (!ibusy) begin
                    ibusy = 1; icnt = 0;
                    itgt = irnd ? int'($urandom_range(0, 2)) : iwait;
                end
                if (icnt >= itgt) begin
                    imem_ready = 1'b1;
                    imem_rdata = imem[imem_addr[15:1]];
                    fetch_q.push_back(imem_addr);
                    ibusy = 0;
                end else begin
                    imem_ready = 1'b0; icnt++;
                end
            end else begin
                imem_ready = ispur; ibusy = 0;
            end
            if (dmem_req) begin
                if (!dbusy) begin
                    dbusy = 1; dcnt = 0;
                    dtgt = drnd ? int'($urandom_range(0, 2)) : dwait;
                end
                if (dcnt >= dtgt) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = dmem[dmem_addr];
                    if (dmem_we) begin
                        dmem[dmem_addr] = dmem_wdata;
                        st_a_q.push_back(dmem_addr);
                        st_d_q.push_back(dmem_wdata);
                    end
                    dbusy = 0;
                end else begin
                    dmem_ready = 1'b0; dcnt++;
                end
            end else begin
                dmem_ready = dspur; dbusy = 0;
            end
            #1;
            if (retire) ret_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        fetch_q.delete(); st_a_q.delete(); st_d_q.delete(); ret_q.delete();
    endtask

    task automatic load_prog();
        for (int i = 0; i < 32768; i++) imem[i] = 16'hF000;
        for (int i = 0; i < 65536; i++) dmem[i] = init_d(i);
        for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk); #3; rst = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        check({tag, "_rst_outs"}, {26'h0, imem_req, dmem_req, dmem_we, retire, halted, trap}, 32'h0);
        clear_logs();
        @(negedge clk); #3; rst = 1'b0;
        #1;
        check({tag, "_boot_req"}, {31'h0, imem_req}, 32'h0);
        @(negedge clk); #2;
        check({tag, "_first_fetch"}, {15'h0, imem_req, imem_addr}, 32'h0001_0000);
    endtask

    task automatic run_until_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk); #2; n++;
        end
        check({tag, "_halt_reached"}, {31'h0, halted}, 32'h1);
    endtask

    // ISA-level interpreter of a straight-line program; yields expected stores and retire count.
    task automatic model_run(output int nret);
        logic [15:0] r [16];
        logic [15:0] mm [int];
        logic [15:0] ins, sx, ea, v;
        int pc;
        exp_a.delete(); exp_d.delete();
        for (int k = 0; k < 16; k++) r[k] = 16'h0;
        nret = 0; pc = 0;
        while (pc < prog.size() && prog[pc][15:12] != 4'hF) begin
            ins = prog[pc];
            sx  = {{12{ins[3]}}, ins[3:0]};
            ea  = r[ins[11:8]] + sx;
            case (ins[15:12])
                4'h0: v = r[ins[11:8]] + r[ins[7:4]];
                4'h1: v = r[ins[11:8]] - r[ins[7:4]];
                4'h2: v = r[ins[11:8]] & r[ins[7:4]];
                4'h3: v = r[ins[11:8]] | r[ins[7:4]];
                4'h4: v = ea;
                4'h5: v = mm.exists(int'(ea)) ? mm[int'(ea)] : init_d(int'(ea));
                default: v = 16'h0;
            endcase
            if (ins[15:12] <= 4'h3 && ins[3:0] != 4'h0) r[ins[3:0]] = v;
            if ((ins[15:12] == 4'h4 || ins[15:12] == 4'h5) && ins[7:4] != 4'h0) r[ins[7:4]] = v;
            if (ins[15:12] == 4'h6) begin
                mm[int'(ea)] = r[ins[7:4]];
                exp_a.push_back(ea);
                exp_d.push_back(r[ins[7:4]]);
            end
            pc++; nret++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, cnt, nret;
        bit stable;

        tbl[0] = '{4'h0, 4'h5, 4'hD, 16'h0002};
        tbl[1] = '{4'h1, 4'h5, 4'hD, 16'h0008};
        tbl[2] = '{4'h1, 4'hD, 4'h5, 16'hFFF8};
        tbl[3] = '{4'h2, 4'hF, 4'h6, 16'h0006};
        tbl[4] = '{4'h3, 4'h5, 4'h8, 16'hFFFD};
        tbl[5] = '{4'h2, 4'h8, 4'h7, 16'h0000};
        tbl[6] = '{4'h0, 4'h8, 4'h8, 16'hFFF0};
        tbl[7] = '{4'h3, 4'h0, 4'h0, 16'h0000};

        // Three dependent instructions with zero-wait memories: commit cadence 4,8,12.
        prog = '{16'h4015, 16'h402D, 16'h0123, 16'h6031, 16'hF000};
        load_prog(); do_reset("seq");
        run_until_halt("seq", 100);
        check("seq_ret0", rq(0), 4);
        check("seq_ret1", rq(1), 8);
        check("seq_ret2", rq(2), 12);
        check("seq_ret3_sw", rq(3), 16);
        check("seq_r3", sd(0), 16'h0002);

        foreach (tbl[i]) begin
            prog = '{{8'h40, 4'h1, tbl[i].a}, {8'h40, 4'h2, tbl[i].b},
                     {tbl[i].op, 12'h123}, 16'h6031, 16'hF000};
            load_prog(); do_reset("alu");
            run_until_halt("alu", 100);
            check($sformatf("alu%0d_addr", i), sa(0), 16'h0001);
            check($sformatf("alu%0d_data", i), sd(0), {16'h0, tbl[i].exp});
        end

        // Load with three wait states and spurious ready pulses before the request.
        prog = '{16'h5045, 16'h6041, 16'hF000};
        dwait = 3; dspur = 1;
        load_prog(); do_reset("lw");
        n = 0;
        while (!dmem_req && n < 50) begin @(negedge clk); #2; n++; end
        dspur = 0;
        cnt = 0; stable = 1;
        while (dmem_req && cnt < 20) begin
            if (dmem_addr != 16'h0005 || dmem_we) stable = 0;
            cnt++;
            @(negedge clk); #2;
        end
        check("lw_req_cycles", cnt, 4);
        check("lw_addr_stable", {31'h0, stable}, 1);
        run_until_halt("lw", 100);
        check("lw_retire", rq(0), 8);
        check("lw_data", sd(0), {16'h0, init_d(5)});
        dwait = 0;

        prog = '{16'h8008};
        load_prog(); imem[8] = 16'h700E; do_reset("beq_t");
        run_until_halt("beq_t", 100);
        check("beq_taken_fetch", fq(2), 16'h000E);
        check("jmp_latency", rq(0), 3);

        prog = '{16'h4011, 16'h8008};
        load_prog(); imem[8] = 16'h701E; do_reset("beq_n");
        run_until_halt("beq_n", 100);
        check("beq_not_taken_fetch", fq(3), 16'h0012);

        prog = '{16'h8FFF};
        load_prog(); do_reset("jmp");
        run_until_halt("jmp", 100);
        check("jmp_fetch", fq(1), 16'h1FFE);

        prog = '{16'h700E};
        load_prog(); imem[16'h7FFF] = 16'h0001; do_reset("wrap");
        repeat (12) @(negedge clk);
        #2;
        check("wrap_branch", fq(1), 16'hFFFE);
        check("wrap_pc", fq(2), 16'h0000);

        prog = '{16'h4007, 16'h0001, 16'h6011, 16'h6002, 16'hF000};
        load_prog(); do_reset("r0");
        run_until_halt("r0", 100);
        check("r0_add", sd(0), 16'h0000);
        check("r0_direct", sd(1), 16'h0000);

        prog = '{16'hF000};
        load_prog(); do_reset("halt");
        run_until_halt("halt", 20);
        cnt = 0;
        repeat (100) begin
            @(negedge clk); #2;
            if (imem_req || dmem_req || !halted) cnt++;
        end
        check("halt_quiet", cnt, 0);
        check("halt_no_retire", ret_q.size(), 0);
        check("halt_no_trap", {31'h0, trap}, 0);

        // Reset while a fetch is stalled; the refetch must start from PC_RST with clean registers.
        prog = '{16'h4015, 16'h4025, 16'h4035, 16'hF000};
        load_prog(); do_reset("mid");
        n = 0;
        while (ret_q.size() < 2 && n < 50) begin @(negedge clk); #2; n++; end
        iwait = 1000;
        repeat (3) @(negedge clk);
        #2;
        check("mid_stalled", {15'h0, imem_req, imem_addr}, 32'h0001_0004);
        imem[0] = 16'h6011; imem[1] = 16'hF000;
        @(negedge clk); #3; rst = 1'b1;
        @(posedge clk); #2;
        check("mid_rst_req", {31'h0, imem_req}, 0);
        iwait = 0;
        clear_logs();
        @(negedge clk); #3; rst = 1'b0;
        run_until_halt("mid", 100);
        check("mid_refetch", fq(0), 16'h0000);
        check("mid_regs_cleared", sd(0), 16'h0000);

        prog = '{16'hA000, 16'h4013, 16'h6011, 16'hF000};
        load_prog(); do_reset("ill");
        run_until_halt("ill", 100);
`ifdef CPU_MC_TRAP_EN
        check("ill_trap", {30'h0, trap, halted}, 32'h3);
        check("ill_no_retire", ret_q.size(), 0);
        check("ill_pc_held", fetch_q.size(), 1);
`else
        check("ill_nop_retire", rq(0), 4);
        check("ill_no_trap", {31'h0, trap}, 0);
        check("ill_continue", sd(0), 16'h0003);
`endif

        // Random straight-line programs with random wait states, register dump via stores.
        irnd = 1; drnd = 1;
        for (int t = 0; t < 3; t++) begin
            prog.delete();
            for (int i = 0; i < 60; i++)
                prog.push_back({4'($urandom_range(0, 6)), 4'($urandom), 4'($urandom), 4'($urandom)});
            for (int k = 1; k < 16; k++) prog.push_back({8'h60, 4'(k), 4'(k)});
            prog.push_back(16'hF000);
            model_run(nret);
            load_prog(); do_reset("rnd");
            run_until_halt("rnd", 4000);
            check($sformatf("rnd%0d_retires", t), ret_q.size(), nret);
            check($sformatf("rnd%0d_nstores", t), st_a_q.size(), exp_a.size());
            for (int i = 0; i < exp_a.size(); i++) begin
                check($sformatf("rnd%0d_st%0d_addr", t, i), sa(i), {16'h0, exp_a[i]});
                check($sformatf("rnd%0d_st%0d_data", t, i), sd(i), {16'h0, exp_d[i]});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
